// File: rtl/mux_scan_sequencer_pkg.sv
// Shared definitions for the mux scan sequencer: FSM encoding, channel geometry
// and the result type of the next-enabled-channel search.
package mux_scan_defs;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Result of a channel search: found=0 means no enabled channel remains
  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } ch_pick_t;

endpackage

// File: rtl/mux_scan_sequencer_settle_timer.sv
// Loadable 4-bit down-counter that measures how long a mux select has been
// held. It parks at zero, and expired is high whenever the count is zero.
module settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       expired
);

  logic [3:0] cnt_q;

  // Count down from the loaded value and stop at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign expired = (cnt_q == 4'd0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for a 4-to-1 mux. It steps the select lines through the
// enabled channels in ascending order, lets each selection settle, samples the
// mux output into a capture word, and then flags that word with a valid pulse.
module mux_scan_sequencer
  import mux_scan_defs::*;
#(
  parameter int SETTLE     = 2,
  parameter int CONTINUOUS = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] en_mask,
  input  logic       mux_out,
  output logic       s1,
  output logic       s0,
  output logic [3:0] sample,
  output logic       valid,
  output logic       busy
);

  // An out-of-range settle time cannot be represented by the dwell counter
  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("mux_scan_sequencer: SETTLE=%0d is outside the legal range 1..15", SETTLE);
  end

  localparam logic [3:0] SETTLE_M1    = 4'(SETTLE - 1);
  localparam logic       AUTO_RESTART = (CONTINUOUS != 0);

  state_t            state_q;
  logic [SEL_W-1:0]  sel_q;
  logic [NUM_CH-1:0] mask_q;
  logic [NUM_CH-1:0] sample_q;
  logic              valid_q;
  logic              busy_q;

  ch_pick_t first_pick;
  ch_pick_t next_pick;
  logic     restart;
  logic     timer_load;
  logic     timer_expired;

  // Lowest enabled channel whose index is at least 'from'
  function automatic ch_pick_t pick_from(input logic [NUM_CH-1:0] mask,
                                         input logic [SEL_W:0]    from);
    ch_pick_t r;
    r = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (mask[k] && (k >= int'(from))) begin
        r.found = 1'b1;
        r.idx   = SEL_W'(k);
      end
    end
    return r;
  endfunction

  // Channel search, scan-launch decision and dwell-timer load strobe
  always_comb begin
    first_pick = pick_from(en_mask, '0);
    next_pick  = pick_from(mask_q, {1'b0, sel_q} + 3'd1);
    restart    = ((state_q == ST_IDLE) && start) ||
                 ((state_q == ST_DONE) && AUTO_RESTART);
    timer_load = (restart && first_pick.found) ||
                 ((state_q == ST_SAMPLE) && next_pick.found);
  end

  settle_timer u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (SETTLE_M1),
    .expired  (timer_expired)
  );

  // Scan FSM with registered select, capture word, valid and busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      mask_q   <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (restart) begin
        // A new scan freezes the mask and starts from an empty capture word
        mask_q   <= en_mask;
        sample_q <= '0;
        busy_q   <= 1'b1;
        if (first_pick.found) begin
          sel_q   <= first_pick.idx;
          state_q <= ST_SELECT;
        end else begin
          state_q <= ST_DONE;
          valid_q <= 1'b1;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            busy_q <= 1'b0;
          end
          ST_SELECT: begin
            if (timer_expired) begin
              state_q <= ST_SAMPLE;
            end
          end
          ST_SAMPLE: begin
            sample_q[sel_q] <= mux_out;
            if (next_pick.found) begin
              sel_q   <= next_pick.idx;
              state_q <= ST_SELECT;
            end else begin
              state_q <= ST_DONE;
              valid_q <= 1'b1;
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign s1     = sel_q[1];
  assign s0     = sel_q[0];
  assign sample = sample_q;
  assign valid  = valid_q;
  assign busy   = busy_q;

endmodule
